gray_auto_binarize: RTL

Downstream consumer of the colour-space conversion stage's luma output. It takes the 24-bit YCbCr pixel stream with its video timing, thresholds luma Y into a black/white image, and passes the result on with matching timing. The threshold is adaptive: the block accumulates the mean luma of each frame and, during vertical blanking, computes that mean with a serial divider. The new mean becomes the threshold for the following frame.

---
 rtl/gray_auto_binarize.sv | 91 +++++++++
 1 files changed

// File: rtl/gray_auto_binarize.sv
// gray_auto_binarize: thresholds luma into a black/white image using the previous frame's mean luma,
// computed by a serial restoring divider during vertical blanking.
module gray_auto_binarize #(
  parameter int CNT_W = 21,
  parameter int SUM_W = 29,
  parameter logic [7:0] INIT_THR = 8'd128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] i_ycbcr,
  input  logic        i_h_sync,
  input  logic        i_v_sync,
  input  logic        i_data_en,
  output logic [23:0] o_bin,
  output logic        o_h_sync,
  output logic        o_v_sync,
  output logic        o_data_en,
  output logic [7:0]  o_threshold,
  output logic        o_thr_valid
);
  localparam logic [1:0] S_IDLE = 2'd0, S_DIV = 2'd1, S_UPD = 2'd2;
  logic [1:0]       r_state;
  logic             r_vs_prev;
  logic [SUM_W-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt, r_div_cnt;
  logic [SUM_W:0]   r_rem;
  logic [7:0]       r_q;
  logic [2:0]       r_k;
  logic [7:0]       w_y;
  logic             w_acc, w_edge, w_ge, w_unused;
  logic [SUM_W-1:0] w_sum_n;
  logic [CNT_W-1:0] w_cnt_n;
  logic [SUM_W:0]   w_sub;
  assign w_y      = i_ycbcr[23:16];
  assign w_unused = ^i_ycbcr[15:0];
  // Accumulators freeze once the count saturates so sum/cnt stay a consistent mean.
  assign w_acc    = i_data_en && (r_cnt != '1);
  assign w_sum_n  = r_sum + (w_acc ? SUM_W'(w_y) : '0);
  assign w_cnt_n  = r_cnt + CNT_W'(w_acc);
  assign w_edge   = i_v_sync && !r_vs_prev;
  assign w_sub    = (SUM_W+1)'(r_div_cnt) << r_k;
  assign w_ge     = r_rem >= w_sub;
  always_ff @(posedge clk) begin
    if (rst) begin
      o_bin       <= '0;
      o_h_sync    <= 1'b0;
      o_v_sync    <= 1'b0;
      o_data_en   <= 1'b0;
      o_threshold <= INIT_THR;
      o_thr_valid <= 1'b0;
      r_state     <= S_IDLE;
      r_vs_prev   <= 1'b1;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_div_cnt   <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_k         <= '0;
    end else begin
      o_bin       <= (i_data_en && w_y >= o_threshold) ? 24'hFFFFFF : 24'h000000;
      o_h_sync    <= i_h_sync;
      o_v_sync    <= i_v_sync;
      o_data_en   <= i_data_en;
      o_thr_valid <= 1'b0;
      r_vs_prev   <= i_v_sync;
      r_sum       <= w_edge ? '0 : w_sum_n;
      r_cnt       <= w_edge ? '0 : w_cnt_n;
      case (r_state)
        S_IDLE: if (w_edge && w_cnt_n != '0) begin
          r_rem     <= (SUM_W+1)'(w_sum_n);
          r_div_cnt <= w_cnt_n;
          r_k       <= 3'd7;
          r_q       <= '0;
          r_state   <= S_DIV;
        end
        S_DIV: begin
          if (w_ge) r_rem <= r_rem - w_sub;
          r_q[r_k] <= w_ge;
          r_k      <= r_k - 3'd1;
          if (r_k == 3'd0) r_state <= S_UPD;
        end
        S_UPD: begin
          o_threshold <= r_q;
          o_thr_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
